disp_scan_ctrl: RTL and testbench

//   Time-multiplexed scan controller for a 4-digit common-anode display.

---
 rtl/disp_pkg.sv | 22 ++
 rtl/scan_prescaler.sv | 33 +++
 rtl/disp_scan_ctrl.sv | 153 +++++++++++++++
 tb/tb_disp_scan_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared types, sizes and the leading-zero rule for the 4-digit scan controller.
package disp_pkg;

   typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

   localparam int NUM_DIGITS = 4;
   localparam int SEL_W      = 2;
   localparam int DIGITS_W   = 4 * NUM_DIGITS;

   // A digit goes dark when blanking is on and it and every more-significant digit are zero.
   function automatic logic lz_suppress(input logic [DIGITS_W-1:0] digits,
                                        input logic [SEL_W-1:0]    sel,
                                        input logic                blank_lz);
      logic dark;
      dark = blank_lz && (sel != '0);
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if ((i >= int'(sel)) && (digits[4*i +: 4] != 4'd0)) dark = 1'b0;
      end
      return dark;
   endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Digit-slot counter: counts 0..TICK_DIV-1 while the scan runs, held at 0 otherwise.
module scan_prescaler #(
   parameter int TICK_DIV  = 100000,
   parameter int BLANK_CYC = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic enable,
   input  logic run,
   output logic slot_start,
   output logic blank_last,
   output logic slot_last
);

   localparam int CNT_W = $clog2(TICK_DIV);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (!enable || !run || slot_last) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign slot_start = (cnt_q == '0);
   assign blank_last = (cnt_q == CNT_W'(BLANK_CYC - 1));
   assign slot_last  = (cnt_q == CNT_W'(TICK_DIV - 1));

endmodule

// File: rtl/disp_scan_ctrl.sv
// Time-multiplexed 4-digit scan controller with inter-digit blanking,
// frame-synchronous digit updates and optional leading-zero suppression.
module disp_scan_ctrl
   import disp_pkg::*;
#(
   parameter int TICK_DIV  = 100000,
   parameter int BLANK_CYC = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic                  load,
   input  logic [DIGITS_W-1:0]   digits_i,
   input  logic [NUM_DIGITS-1:0] dp_i,
   input  logic                  blank_lz,
   output logic [SEL_W-1:0]      sel_o,
   output logic                  en_n_o,
   output logic [3:0]            nibble_o,
   output logic                  dp_o,
   output logic                  frame_done
);

   state_t                state_q, state_d;
   logic [SEL_W-1:0]      sel_q, sel_d, slot_sel;
   logic                  en_n_q, en_n_d;
   logic [3:0]            nibble_q, nibble_d;
   logic                  dp_q, dp_d;
   logic                  frame_done_q, frame_done_d;
   logic                  supp_q, supp_d, supp_now;
   logic                  new_slot;
   logic [DIGITS_W-1:0]   act_dig_q, act_dig_d, pend_dig_q, pend_dig_d, slot_dig;
   logic [NUM_DIGITS-1:0] act_dp_q, act_dp_d, pend_dp_q, pend_dp_d, slot_dp;
   logic                  slot_start, blank_last, slot_last;

   scan_prescaler #(
      .TICK_DIV  (TICK_DIV),
      .BLANK_CYC (BLANK_CYC)
   ) u_prescaler (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .run        (state_q != IDLE),
      .slot_start (slot_start),
      .blank_last (blank_last),
      .slot_last  (slot_last)
   );

   assign supp_now = lz_suppress(act_dig_q, sel_q, blank_lz);

   always_comb begin
      state_d      = state_q;
      sel_d        = sel_q;
      en_n_d       = en_n_q;
      nibble_d     = nibble_q;
      dp_d         = dp_q;
      frame_done_d = 1'b0;
      supp_d       = supp_q;
      act_dig_d    = act_dig_q;
      act_dp_d     = act_dp_q;
      pend_dig_d   = load ? digits_i : pend_dig_q;
      pend_dp_d    = load ? dp_i : pend_dp_q;
      new_slot     = 1'b0;
      slot_sel     = sel_q;
      slot_dig     = act_dig_q;
      slot_dp      = act_dp_q;

      if (!enable) begin
         state_d = IDLE;
         sel_d   = '0;
         en_n_d  = 1'b1;
      end else begin
         case (state_q)
            // Starting from dark is a frame start: the latest pending digits go live at once.
            IDLE: begin
               state_d  = BLANK;
               new_slot = 1'b1;
               slot_sel = '0;
               slot_dig = pend_dig_d;
               slot_dp  = pend_dp_d;
            end
            BLANK: begin
               if (slot_start) supp_d = supp_now;
               if (blank_last) begin
                  state_d = SHOW;
                  en_n_d  = slot_start ? supp_now : supp_q;
               end
            end
            SHOW: begin
               if (slot_last) begin
                  state_d  = BLANK;
                  new_slot = 1'b1;
                  slot_sel = sel_q + SEL_W'(1);
                  if (sel_q == SEL_W'(NUM_DIGITS - 1)) begin
                     frame_done_d = 1'b1;
                     slot_dig     = pend_dig_d;
                     slot_dp      = pend_dp_d;
                  end
               end
            end
            default: begin
               state_d = IDLE;
               sel_d   = '0;
               en_n_d  = 1'b1;
            end
         endcase
      end

      // Digit value and point switch together with the select and hold for the whole slot.
      if (new_slot) begin
         sel_d     = slot_sel;
         en_n_d    = 1'b1;
         act_dig_d = slot_dig;
         act_dp_d  = slot_dp;
         nibble_d  = slot_dig[{slot_sel, 2'b00} +: 4];
         dp_d      = slot_dp[slot_sel];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         sel_q        <= '0;
         en_n_q       <= 1'b1;
         nibble_q     <= '0;
         dp_q         <= 1'b0;
         frame_done_q <= 1'b0;
         supp_q       <= 1'b0;
         act_dig_q    <= '0;
         act_dp_q     <= '0;
         pend_dig_q   <= '0;
         pend_dp_q    <= '0;
      end else begin
         state_q      <= state_d;
         sel_q        <= sel_d;
         en_n_q       <= en_n_d;
         nibble_q     <= nibble_d;
         dp_q         <= dp_d;
         frame_done_q <= frame_done_d;
         supp_q       <= supp_d;
         act_dig_q    <= act_dig_d;
         act_dp_q     <= act_dp_d;
         pend_dig_q   <= pend_dig_d;
         pend_dp_q    <= pend_dp_d;
      end
   end

   assign sel_o      = sel_q;
   assign en_n_o     = en_n_q;
   assign nibble_o   = nibble_q;
   assign dp_o       = dp_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Bench for disp_scan_ctrl: directed sequences, a per-slot vector table and a
// randomized run against a time-based reference model.
module tb_disp_scan_ctrl;

   localparam int TICK_DIV  = 8;
   localparam int BLANK_CYC = 2;
   localparam int FRAME     = 4 * TICK_DIV;

   logic        clk      = 1'b0;
   logic        rst_n    = 1'b1;
   logic        enable   = 1'b0;
   logic        load     = 1'b0;
   logic        blank_lz = 1'b0;
   logic [15:0] digits_i = 16'd0;
   logic [3:0]  dp_i     = 4'd0;
   logic [1:0]  sel_o;
   logic        en_n_o;
   logic [3:0]  nibble_o;
   logic        dp_o;
   logic        frame_done;

   int checks   = 0;
   int failures = 0;

   // Reference model: m_t counts cycles since the current run's first slot began.
   bit          m_run;
   int          m_t;
   logic [15:0] m_pend_dig, m_frm_dig;
   logic [3:0]  m_pend_dp, m_frm_dp;
   bit          m_supp;

   typedef struct {
      logic [15:0] dig;
      logic [3:0]  dp;
      logic        lz;
      logic [3:0]  dark;
   } vec_t;

   vec_t tbl [8];

   disp_scan_ctrl #(
      .TICK_DIV  (TICK_DIV),
      .BLANK_CYC (BLANK_CYC)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .load       (load),
      .digits_i   (digits_i),
      .dp_i       (dp_i),
      .blank_lz   (blank_lz),
      .sel_o      (sel_o),
      .en_n_o     (en_n_o),
      .nibble_o   (nibble_o),
      .dp_o       (dp_o),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit lz_dark(input logic [15:0] d, input int n, input bit lz);
      return lz && (n != 0) && ((d >> (4 * n)) == 16'd0);
   endfunction

   task automatic model_reset();
      m_run      = 1'b0;
      m_t        = 0;
      m_pend_dig = 16'd0;
      m_frm_dig  = 16'd0;
      m_pend_dp  = 4'd0;
      m_frm_dp   = 4'd0;
      m_supp     = 1'b0;
   endtask

   task automatic check_cycle();
      int         slot, pos;
      logic [8:0] exp_v, act_v;
      if (!m_run) begin
         chk("idle", {12'd0, sel_o, en_n_o, frame_done}, {12'd0, 2'd0, 1'b1, 1'b0});
      end else begin
         slot  = (m_t / TICK_DIV) % 4;
         pos   = m_t % TICK_DIV;
         exp_v = {2'(slot), (pos < BLANK_CYC) || m_supp, (m_t > 0) && (m_t % FRAME == 0),
                  m_frm_dig[4*slot +: 4], m_frm_dp[slot]};
         act_v = {sel_o, en_n_o, frame_done, nibble_o, dp_o};
         chk("scan", {7'd0, act_v}, {7'd0, exp_v});
      end
   endtask

   // Advance the model across the coming clock edge using the inputs it will sample.
   task automatic advance_model();
      logic [15:0] nd;
      logic [3:0]  np;
      if (m_run && (m_t % TICK_DIV == 0))
         m_supp = lz_dark(m_frm_dig, (m_t / TICK_DIV) % 4, blank_lz);
      nd = load ? digits_i : m_pend_dig;
      np = load ? dp_i : m_pend_dp;
      if (!enable) begin
         m_run = 1'b0;
      end else if (!m_run) begin
         m_run     = 1'b1;
         m_t       = 0;
         m_frm_dig = nd;
         m_frm_dp  = np;
      end else begin
         m_t++;
         if (m_t % FRAME == 0) begin
            m_frm_dig = nd;
            m_frm_dp  = np;
         end
      end
      m_pend_dig = nd;
      m_pend_dp  = np;
   endtask

   task automatic tick();
      @(negedge clk);
      check_cycle();
      if (rst_n) advance_model();
      else model_reset();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   task automatic wait_frame(input string name);
      int n;
      n = 0;
      tick();
      while (!frame_done && n < 2 * FRAME) begin
         tick();
         n++;
      end
      chk(name, {15'd0, frame_done}, 16'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]  en_pat;
      logic [15:0] nib;
      bit          fd_seen;

      tbl[0] = '{16'h1234, 4'b0101, 1'b0, 4'b0000};
      tbl[1] = '{16'h0050, 4'b0000, 1'b1, 4'b1100};
      tbl[2] = '{16'h0000, 4'b1000, 1'b1, 4'b1110};
      tbl[3] = '{16'h0000, 4'b0000, 1'b0, 4'b0000};
      tbl[4] = '{16'h0105, 4'b0010, 1'b1, 4'b1000};
      tbl[5] = '{16'h0007, 4'b0000, 1'b1, 4'b1110};
      tbl[6] = '{16'h9000, 4'b1111, 1'b1, 4'b0000};
      tbl[7] = '{16'h0406, 4'b0001, 1'b1, 4'b1000};

      model_reset();
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_values", {7'd0, sel_o, en_n_o, nibble_o, dp_o, frame_done},
          {7'd0, 2'd0, 1'b1, 4'd0, 1'b0, 1'b0});
      rst_n = 1'b1;
      ticks(2);

      // Basic scan of 1234
      digits_i = 16'h1234;
      dp_i     = 4'b0000;
      load     = 1'b1;
      tick();
      load     = 1'b0;
      enable   = 1'b1;
      tick();
      en_pat  = 8'd0;
      nib     = 16'd0;
      fd_seen = 1'b0;
      for (int i = 0; i < FRAME; i++) begin
         if (i < TICK_DIV) en_pat[i] = en_n_o;
         if (i % TICK_DIV == 4) nib[4*(i/TICK_DIV) +: 4] = nibble_o;
         fd_seen |= frame_done;
         tick();
      end
      chk("slot0_en_pattern", {8'd0, en_pat}, 16'h0003);
      chk("frame_nibbles", nib, 16'h1234);
      chk("no_early_frame_done", {15'd0, fd_seen}, 16'd0);
      chk("frame_done_at_32", {14'd0, sel_o, frame_done} == {14'd0, 2'd0, 1'b1}, 16'd1);

      // Tear-free update: load mid-frame at slot 2
      ticks(16);
      digits_i = 16'h5678;
      load     = 1'b1;
      tick();
      load     = 1'b0;
      ticks(3);
      chk("tear_slot2", {10'd0, sel_o, nibble_o}, {10'd0, 2'd2, 4'h2});
      ticks(8);
      chk("tear_slot3", {10'd0, sel_o, nibble_o}, {10'd0, 2'd3, 4'h1});
      ticks(4);
      chk("tear_boundary", {15'd0, frame_done}, 16'd1);
      ticks(4);
      chk("tear_new_slot0", {10'd0, sel_o, nibble_o}, {10'd0, 2'd0, 4'h8});
      ticks(8);
      chk("tear_new_slot1", {9'd0, sel_o, en_n_o, nibble_o}, {9'd0, 2'd1, 1'b0, 4'h7});

      // Disable mid-SHOW at slot 1, then re-enable
      enable = 1'b0;
      tick();
      chk("disable_next_edge", {13'd0, sel_o, en_n_o, frame_done}, {13'd0, 2'd0, 1'b1, 1'b0});
      ticks(3);
      enable = 1'b1;
      tick();
      chk("reenable_slot0_blank", {9'd0, sel_o, en_n_o, nibble_o}, {9'd0, 2'd0, 1'b1, 4'h8});
      ticks(2);
      chk("reenable_slot0_show", {11'd0, en_n_o, nibble_o}, {11'd0, 1'b0, 4'h8});

      // Load coincident with the frame-boundary edge
      for (int n = 0; n < 2 * FRAME && (m_t % FRAME != FRAME - 1); n++) tick();
      digits_i = 16'h9ABC;
      dp_i     = 4'b0001;
      load     = 1'b1;
      tick();
      load     = 1'b0;
      chk("coincident_load", {10'd0, frame_done, nibble_o, dp_o}, {10'd0, 1'b1, 4'hC, 1'b1});
      ticks(2);
      chk("coincident_show", {11'd0, en_n_o, nibble_o}, {11'd0, 1'b0, 4'hC});

      // Table of frame contents with per-slot expectations
      for (int v = 0; v < 8; v++) begin
         digits_i = tbl[v].dig;
         dp_i     = tbl[v].dp;
         blank_lz = tbl[v].lz;
         load     = 1'b1;
         tick();
         load     = 1'b0;
         wait_frame("table_frame_wait");
         for (int s = 0; s < 4; s++) begin
            ticks(4);
            chk("table_slot", {8'd0, sel_o, en_n_o, nibble_o, dp_o},
                {8'd0, 2'(s), tbl[v].dark[s], tbl[v].dig[4*s +: 4], tbl[v].dp[s]});
            ticks(4);
         end
      end

      // Randomized run checked against the model every cycle
      blank_lz = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         load = ($urandom_range(0, 15) == 0);
         if (load) begin
            for (int k = 0; k < 4; k++)
               digits_i[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 9)) : 4'd0;
            dp_i = 4'($urandom);
         end
         if ($urandom_range(0, 63) == 0) blank_lz = ~blank_lz;
         if (enable && $urandom_range(0, 199) == 0) enable = 1'b0;
         else if (!enable && $urandom_range(0, 3) == 0) enable = 1'b1;
         tick();
      end
      load     = 1'b0;
      blank_lz = 1'b0;

      // Asynchronous reset in SHOW of slot 1
      enable   = 1'b0;
      digits_i = 16'h8765;
      dp_i     = 4'b0000;
      load     = 1'b1;
      tick();
      load   = 1'b0;
      enable = 1'b1;
      tick();
      ticks(12);
      chk("pre_reset_show", {9'd0, sel_o, en_n_o, nibble_o}, {9'd0, 2'd1, 1'b0, 4'h6});
      #2 rst_n = 1'b0;
      enable = 1'b0;
      #1;
      chk("async_reset", {7'd0, sel_o, en_n_o, nibble_o, dp_o, frame_done},
          {7'd0, 2'd0, 1'b1, 4'd0, 1'b0, 1'b0});
      model_reset();
      @(posedge clk);
      #1;
      ticks(2);
      rst_n = 1'b1;
      ticks(3);
      enable = 1'b1;
      tick();
      chk("post_reset_slot0", {9'd0, sel_o, en_n_o, nibble_o}, {9'd0, 2'd0, 1'b1, 4'h0});
      ticks(12);
      chk("post_reset_slot1", {9'd0, sel_o, en_n_o, nibble_o}, {9'd0, 2'd1, 1'b0, 4'h0});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
